// File: rtl/slc3_mem_pkg.sv
// Shared types and defaults for the SLC-3 SRAM arbiter.
//   mem_state_t : access sequencer states
//   req_id_t    : requester identity (CPU / program loader)
//   mem_req_t   : one requester's access payload
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } mem_state_t;

    typedef enum logic {
        CPU,
        LDR
    } req_id_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

    localparam logic [15:0]  DEFAULT_IO_ADDR     = 16'hFFFF;
    localparam int unsigned  DEFAULT_WAIT_CYCLES = 2;
    localparam int unsigned  DEFAULT_ADDR_W      = 20;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between CPU and loader.
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_cpu_req          : CPU request
//   i_ldr_req          : loader request
//   i_update           : commit current winner as the last-granted requester
//   o_valid_c          : some requester is present (combinational)
//   o_winner_c         : granted requester (combinational)
module rr_arb2
    import slc3_mem_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    i_cpu_req,
    input  logic    i_ldr_req,
    input  logic    i_update,
    output logic    o_valid_c,
    output req_id_t o_winner_c
);

    req_id_t r_rr_last;

    // Sole requester wins; on a tie the one not served last wins.
    always_comb begin
        o_valid_c  = i_cpu_req | i_ldr_req;
        o_winner_c = CPU;
        if (i_cpu_req && i_ldr_req) begin
            o_winner_c = (r_rr_last == CPU) ? LDR : CPU;
        end else if (i_ldr_req) begin
            o_winner_c = LDR;
        end
    end

    // Starting from LDR lets the CPU win the first tie.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_last <= LDR;
        end else if (i_update) begin
            r_rr_last <= o_winner_c;
        end
    end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// Shares the external SRAM between the SLC-3 CPU and the loader/debug port.
// Sequences reads/writes with active-low strobes and decodes the
// memory-mapped switch/hex word at IO_ADDR.
// Ports:
//   i_clk, i_reset                  : clock, synchronous active-high reset
//   i_cpu_* / o_cpu_*               : CPU request, read data, ready pulse
//   i_ldr_* / o_ldr_*               : loader request, read data, ready pulse
//   i_s                             : switch inputs (read at IO_ADDR)
//   o_hex_out                       : hex display register (written at IO_ADDR)
//   o_ce, o_oe, o_we, o_ub, o_lb    : SRAM strobes, active-low
//   o_addr                          : SRAM address
//   o_sram_dq_out, o_sram_dq_oe     : write data and its output enable
//   i_sram_dq_in                    : SRAM data pin as seen by the block
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter logic [15:0] IO_ADDR     = DEFAULT_IO_ADDR,
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W
)
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [15:0]       i_cpu_addr,
    input  logic [15:0]       i_cpu_wdata,
    output logic [15:0]       o_cpu_rdata,
    output logic              o_cpu_ready,
    input  logic              i_ldr_req,
    input  logic              i_ldr_we,
    input  logic [15:0]       i_ldr_addr,
    input  logic [15:0]       i_ldr_wdata,
    output logic [15:0]       o_ldr_rdata,
    output logic              o_ldr_ready,
    input  logic [15:0]       i_s,
    output logic [15:0]       o_hex_out,
    output logic              o_ce,
    output logic              o_oe,
    output logic              o_we,
    output logic              o_ub,
    output logic              o_lb,
    output logic [ADDR_W-1:0] o_addr,
    output logic [15:0]       o_sram_dq_out,
    output logic              o_sram_dq_oe,
    input  logic [15:0]       i_sram_dq_in
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    mem_state_t       r_state;
    req_id_t          r_owner;
    logic             r_we;
    logic [CNT_W-1:0] r_cnt;

    logic             w_valid_c;
    req_id_t          w_winner_c;
    mem_req_t         w_win_req;
    logic             w_is_io;
    logic             w_update;

    rr_arb2 u_rr_arb2 (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_cpu_req  (i_cpu_req),
        .i_ldr_req  (i_ldr_req),
        .i_update   (w_update),
        .o_valid_c  (w_valid_c),
        .o_winner_c (w_winner_c)
    );

    // Winner's request payload and address decode.
    always_comb begin
        w_win_req.we    = i_cpu_we;
        w_win_req.addr  = i_cpu_addr;
        w_win_req.wdata = i_cpu_wdata;
        if (w_winner_c == LDR) begin
            w_win_req.we    = i_ldr_we;
            w_win_req.addr  = i_ldr_addr;
            w_win_req.wdata = i_ldr_wdata;
        end
        w_is_io  = (w_win_req.addr == IO_ADDR);
        w_update = (r_state == IDLE) && w_valid_c;
    end

    // Access sequencer; strobes are registered so each state's values
    // are set on the edge that enters it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_owner       <= CPU;
            r_we          <= 1'b0;
            r_cnt         <= '0;
            o_cpu_rdata   <= '0;
            o_cpu_ready   <= 1'b0;
            o_ldr_rdata   <= '0;
            o_ldr_ready   <= 1'b0;
            o_hex_out     <= '0;
            o_ce          <= 1'b1;
            o_oe          <= 1'b1;
            o_we          <= 1'b1;
            o_ub          <= 1'b1;
            o_lb          <= 1'b1;
            o_addr        <= '0;
            o_sram_dq_out <= '0;
            o_sram_dq_oe  <= 1'b0;
        end else begin
            o_cpu_ready <= 1'b0;
            o_ldr_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid_c) begin
                        r_owner <= w_winner_c;
                        r_we    <= w_win_req.we;
                        if (w_is_io) begin
                            // I/O word completes without touching the SRAM.
                            if (w_win_req.we) begin
                                o_hex_out <= w_win_req.wdata;
                            end else if (w_winner_c == LDR) begin
                                o_ldr_rdata <= i_s;
                            end else begin
                                o_cpu_rdata <= i_s;
                            end
                            if (w_winner_c == LDR) begin
                                o_ldr_ready <= 1'b1;
                            end else begin
                                o_cpu_ready <= 1'b1;
                            end
                            r_state <= DONE;
                        end else begin
                            o_ce   <= 1'b0;
                            o_ub   <= 1'b0;
                            o_lb   <= 1'b0;
                            o_addr <= ADDR_W'(w_win_req.addr);
                            if (w_win_req.we) begin
                                // Data driven one cycle ahead of WE.
                                o_sram_dq_out <= w_win_req.wdata;
                                o_sram_dq_oe  <= 1'b1;
                                o_oe          <= 1'b1;
                                o_we          <= 1'b1;
                            end else begin
                                o_oe <= 1'b0;
                            end
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_cnt <= CNT_W'(WAIT_CYCLES - 1);
                    if (r_we) begin
                        o_we <= 1'b0;
                    end
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (r_cnt == '0) begin
                        o_ce         <= 1'b1;
                        o_oe         <= 1'b1;
                        o_we         <= 1'b1;
                        o_ub         <= 1'b1;
                        o_lb         <= 1'b1;
                        o_sram_dq_oe <= 1'b0;
                        if (r_owner == LDR) begin
                            o_ldr_ready <= 1'b1;
                            if (!r_we) begin
                                o_ldr_rdata <= i_sram_dq_in;
                            end
                        end else begin
                            o_cpu_ready <= 1'b1;
                            if (!r_we) begin
                                o_cpu_rdata <= i_sram_dq_in;
                            end
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed bench for slc3_mem_arbiter with a behavioural SRAM model.
module tb_slc3_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ready;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ldr_req, ldr_we, ldr_ready;
    logic [15:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic [15:0] s, hex_out;
    logic        ce, oe, we_n, ub, lb;
    logic [19:0] addr;
    logic [15:0] dq_out, dq_in;
    logic        dq_oe;

    logic [15:0] mem [0:65535];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    slc3_mem_arbiter #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF), .ADDR_W(20)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready),
        .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr),
        .i_ldr_wdata(ldr_wdata), .o_ldr_rdata(ldr_rdata), .o_ldr_ready(ldr_ready),
        .i_s(s), .o_hex_out(hex_out),
        .o_ce(ce), .o_oe(oe), .o_we(we_n), .o_ub(ub), .o_lb(lb),
        .o_addr(addr), .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe),
        .i_sram_dq_in(dq_in)
    );

    // Asynchronous SRAM: writes land while CE and WE are low.
    always @(posedge clk) begin
        if (!ce && !we_n) mem[addr[15:0]] <= dq_out;
    end
    assign dq_in = mem[addr[15:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request from idle; lat = cycle in which ready was seen.
    task automatic access(input bit is_ldr, input bit wr, input logic [15:0] a,
                          input logic [15:0] d, output int lat, output logic [15:0] rd,
                          output int n_ce, output int n_we, output int n_oe,
                          output logic [19:0] a_seen, output int n_other);
        lat = 0; n_ce = 0; n_we = 0; n_oe = 0; n_other = 0;
        rd = '0; a_seen = '0;
        if (is_ldr) begin
            ldr_we = wr; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
        end else begin
            cpu_we = wr; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (!ce) begin n_ce++; a_seen = addr; end
            if (!we_n) n_we++;
            if (dq_oe) n_oe++;
            if (is_ldr ? cpu_ready : ldr_ready) n_other++;
            if (is_ldr ? ldr_ready : cpu_ready) begin
                rd = is_ldr ? ldr_rdata : cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        tick();
    endtask

    int          lat, n_ce, n_we, n_oe, n_other;
    logic [15:0] rd;
    logic [19:0] a_seen;
    int          t_cpu, t_ldr, n_ev, n_dual;
    int          ev_t [4];
    int          ev_id [4];

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        s = 16'h0000;

        // Reset values
        tick(); tick();
        check("rst_strobes", {27'd0, ce, oe, we_n, ub, lb}, 32'h1F);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_addr", {12'd0, addr}, 32'd0);
        check("rst_dq_out", {16'd0, dq_out}, 32'd0);
        check("rst_hex", {16'd0, hex_out}, 32'd0);
        check("rst_ready", {30'd0, cpu_ready, ldr_ready}, 32'd0);
        check("rst_rdata", {cpu_rdata, ldr_rdata}, 32'd0);
        reset = 1'b0;
        tick();

        // CPU write x1234 -> x0010
        access(1'b0, 1'b1, 16'h0010, 16'h1234, lat, rd, n_ce, n_we, n_oe, a_seen, n_other);
        check("wr_lat", lat, 4);
        check("wr_we_low", n_we, 2);
        check("wr_dq_oe", n_oe, 3);
        check("wr_ce_low", n_ce, 3);
        check("wr_addr", {12'd0, a_seen}, 32'h10);
        check("wr_mem", {16'd0, mem[16'h0010]}, 32'h1234);
        check("wr_other_rdy", n_other, 0);

        // CPU read back
        access(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, n_ce, n_we, n_oe, a_seen, n_other);
        check("rd_lat", lat, 4);
        check("rd_data", {16'd0, rd}, 32'h1234);
        check("rd_we_low", n_we, 0);
        check("rd_dq_oe", n_oe, 0);
        check("rd_ready_pulse", {31'd0, cpu_ready}, 32'd0);
        check("rd_data_held", {16'd0, cpu_rdata}, 32'h1234);

        // Loader preloads x0020 for the tie test
        access(1'b1, 1'b1, 16'h0020, 16'h5A5A, lat, rd, n_ce, n_we, n_oe, a_seen, n_other);
        check("ldr_wr_lat", lat, 4);

        // Simultaneous reads, each dropped on its own ready
        cpu_we = 0; cpu_addr = 16'h0010; ldr_we = 0; ldr_addr = 16'h0020;
        cpu_req = 1; ldr_req = 1;
        t_cpu = 0; t_ldr = 0; n_dual = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_ready && ldr_ready) n_dual++;
            if (cpu_ready) begin t_cpu = i; cpu_req = 0; end
            if (ldr_ready) begin t_ldr = i; ldr_req = 0; break; end
        end
        cpu_req = 0; ldr_req = 0;
        tick();
        check("tie_cpu_lat", t_cpu, 4);
        check("tie_ldr_lat", t_ldr, 9);
        check("tie_cpu_data", {16'd0, cpu_rdata}, 32'h1234);
        check("tie_ldr_data", {16'd0, ldr_rdata}, 32'h5A5A);
        check("tie_dual_rdy", n_dual, 0);

        // Both held: grants alternate
        cpu_req = 1; ldr_req = 1; n_ev = 0; n_dual = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (cpu_ready && ldr_ready) n_dual++;
            if (cpu_ready || ldr_ready) begin
                if (n_ev < 4) begin
                    ev_t[n_ev]  = i;
                    ev_id[n_ev] = ldr_ready ? 1 : 0;
                end
                n_ev++;
                if (n_ev == 4) begin cpu_req = 0; ldr_req = 0; break; end
            end
        end
        cpu_req = 0; ldr_req = 0;
        tick();
        check("alt_count", n_ev, 4);
        check("alt_t0", ev_t[0], 4);
        check("alt_t1", ev_t[1], 9);
        check("alt_t2", ev_t[2], 14);
        check("alt_t3", ev_t[3], 19);
        check("alt_ids", {28'd0, ev_id[0][0], ev_id[1][0], ev_id[2][0], ev_id[3][0]}, 32'b0101);
        check("alt_dual_rdy", n_dual, 0);

        // I/O read returns switches
        s = 16'hEEEE;
        access(1'b0, 1'b0, 16'hFFFF, 16'h0000, lat, rd, n_ce, n_we, n_oe, a_seen, n_other);
        check("io_rd_lat", lat, 1);
        check("io_rd_data", {16'd0, rd}, 32'hEEEE);
        check("io_rd_ce", n_ce, 0);

        // I/O write updates hex display
        access(1'b0, 1'b1, 16'hFFFF, 16'h00A0, lat, rd, n_ce, n_we, n_oe, a_seen, n_other);
        check("io_wr_lat", lat, 1);
        check("io_wr_hex", {16'd0, hex_out}, 32'h00A0);
        check("io_wr_ce", n_ce, 0);
        check("io_wr_we", n_we, 0);
        check("io_wr_dq_oe", n_oe, 0);

        // Loader burst of 16 writes
        for (int k = 0; k < 16; k++) begin
            access(1'b1, 1'b1, 16'h0100 + 16'(k), 16'hC000 + 16'(k), lat, rd,
                   n_ce, n_we, n_oe, a_seen, n_other);
            check($sformatf("burst_lat_%0d", k), lat, 4);
            check($sformatf("burst_addr_%0d", k), {12'd0, a_seen}, 32'h100 + 32'(k));
            check($sformatf("burst_we_%0d", k), n_we, 2);
        end
        for (int k = 0; k < 16; k += 5) begin
            check($sformatf("burst_mem_%0d", k), {16'd0, mem[16'h0100 + 16'(k)]},
                  32'hC000 + 32'(k));
        end

        // Reset held three cycles in the middle of an access
        cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
        tick(); tick();
        check("mid_in_access", {31'd0, ce}, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid_rst_strobes_%0d", k), {29'd0, ce, oe, we_n}, 32'h7);
            check($sformatf("mid_rst_dq_oe_%0d", k), {31'd0, dq_oe}, 32'd0);
            check($sformatf("mid_rst_rdy_%0d", k), {31'd0, cpu_ready}, 32'd0);
        end
        reset = 1'b0; cpu_req = 0;
        tick();
        check("mid_post_rdy", {31'd0, cpu_ready}, 32'd0);
        check("mid_post_ce", {31'd0, ce}, 32'd1);
        check("mid_post_rdata", {16'd0, cpu_rdata}, 32'd0);
        access(1'b0, 1'b0, 16'h0010, 16'h0000, lat, rd, n_ce, n_we, n_oe, a_seen, n_other);
        check("mid_after_lat", lat, 4);
        check("mid_after_data", {16'd0, rd}, 32'h1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
